// File: rtl/sample_demultiplexer_if.sv
// Valid/ready stream bundle used on both sides of the sample demultiplexer.
// The master drives rdy/data, and the slave returns ack.
interface sample_demultiplexer_if #(
    parameter int WIDTH = 8
) ();
    logic             rdy;
    logic [WIDTH-1:0] data;
    logic             ack;

    modport master (output rdy, output data, input ack);
    modport slave  (input rdy, input data, output ack);
endinterface

// File: rtl/sample_demultiplexer.sv
// Reassembles an LSB-first byte stream into BYTES_PER_REC-byte timetag records and counts lost records.
// Define SAMPLE_DEMUX_TIMEOUT_EN to discard a partial record after TIMEOUT_CYCLES idle cycles.
module sample_demultiplexer #(
    parameter int BYTES_PER_REC  = 6,
    parameter int LOST_CNT_W     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sample_demultiplexer_if.slave  in_bus,
    sample_demultiplexer_if.master out_bus,
    output logic [LOST_CNT_W-1:0] lost_count,
    output logic                  resync_err
);

    localparam int REC_W = 8 * BYTES_PER_REC;
    localparam int IDX_W = $clog2(BYTES_PER_REC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_REC - 1);

    logic [IDX_W-1:0]      byte_idx;
    logic [REC_W-9:0]      assembly;
    logic [REC_W-1:0]      record_q;
    logic                  record_rdy_q;
    logic [LOST_CNT_W-1:0] lost_q;
    logic                  data_ack;
    logic                  xfer;
    logic                  last_xfer;
    logic                  deliver;
    logic                  timeout;

    // NOTE: data_ack depends only on registered state and record_ack, never on data_rdy or data.
    assign data_ack  = (byte_idx != LAST_IDX) | ~record_rdy_q | out_bus.ack;
    assign xfer      = in_bus.rdy & data_ack;
    assign last_xfer = xfer & (byte_idx == LAST_IDX);
    assign deliver   = record_rdy_q & out_bus.ack;

`ifdef SAMPLE_DEMUX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              resync_q;

    // A transfer in the would-be timeout cycle wins, so the partial record survives.
    assign timeout = ~xfer & (byte_idx != '0) & (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
            resync_q <= 1'b0;
        end else begin
            resync_q <= timeout;
            if (xfer || byte_idx == '0 || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign resync_err = resync_q;
`else
    assign timeout    = 1'b0;
    assign resync_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= '0;
            assembly <= '0;
        end else if (xfer) begin
            if (byte_idx == LAST_IDX) begin
                byte_idx <= '0;
            end else begin
                byte_idx                   <= byte_idx + 1'b1;
                assembly[8*byte_idx +: 8]  <= in_bus.data;
            end
        end else if (timeout) begin
            byte_idx <= '0;
            assembly <= '0;
        end
    end

    // The final byte bypasses the assembly register and lands directly in the output record.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            record_rdy_q <= 1'b0;
            record_q     <= '0;
        end else if (last_xfer) begin
            record_rdy_q <= 1'b1;
            record_q     <= {in_bus.data, assembly};
        end else if (deliver) begin
            record_rdy_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lost_q <= '0;
        else if (deliver && record_q[REC_W-1] && !(&lost_q))
            lost_q <= lost_q + 1'b1;
    end

    assign in_bus.ack   = data_ack;
    assign out_bus.rdy  = record_rdy_q;
    assign out_bus.data = record_q;
    assign lost_count   = lost_q;

endmodule

// File: tb/tb_sample_demultiplexer.sv
// Directed bench for sample_demultiplexer: scoreboard of expected records, plus a 2-bit
// lost-counter twin that sees identical traffic to exercise counter saturation.
module tb_sample_demultiplexer;

    localparam int REC_W    = 48;
    localparam int TIMEOUT  = 1024;
    localparam int WAIT_MAX = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] lost_count;
    logic        resync_err;
    logic [1:0]  lost_sat;
    logic        resync_sat;

    always #5 clk = ~clk;

    sample_demultiplexer_if #(.WIDTH(8))     in_if ();
    sample_demultiplexer_if #(.WIDTH(REC_W)) out_if ();
    sample_demultiplexer_if #(.WIDTH(8))     in_s ();
    sample_demultiplexer_if #(.WIDTH(REC_W)) out_s ();

    assign in_s.rdy  = in_if.rdy;
    assign in_s.data = in_if.data;
    assign out_s.ack = out_if.ack;

    sample_demultiplexer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_bus     (in_if),
        .out_bus    (out_if),
        .lost_count (lost_count),
        .resync_err (resync_err)
    );

    sample_demultiplexer #(.LOST_CNT_W(2)) dut_sat (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_bus     (in_s),
        .out_bus    (out_s),
        .lost_count (lost_sat),
        .resync_err (resync_sat)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int main_lost = 0;
    int sat_lost = 0;
    int ack_drops = 0;
    bit watch_ack = 1'b0;
    logic [REC_W-1:0] exp_q[$];
    int deliv_cyc[$];
    bit held = 1'b0;
    logic [REC_W-1:0] held_rec;

    function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard side: compares every delivered record and checks stall stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_rdy", 64'(out_if.rdy), 64'd1);
                check("hold_record", 64'(out_if.data), 64'(held_rec));
            end
            if (out_if.rdy && out_if.ack) begin
                check("sb_underflow", 64'(exp_q.size() == 0), 64'd0);
                if (exp_q.size() != 0) begin
                    logic [REC_W-1:0] e;
                    e = exp_q.pop_front();
                    check("record", 64'(out_if.data), 64'(e));
                    if (e[REC_W-1]) begin
                        main_lost = (main_lost == 65535) ? 65535 : main_lost + 1;
                        sat_lost  = (sat_lost == 3) ? 3 : sat_lost + 1;
                    end
                end
                deliv_cyc.push_back(cyc + 1);
            end
            if (watch_ack && in_if.rdy && !in_if.ack) ack_drops++;
            held     = out_if.rdy && !out_if.ack;
            held_rec = out_if.data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_if.rdy  = 1'b1;
        in_if.data = b;
        @(negedge clk);
        while (!in_if.ack && n < WAIT_MAX) begin
            n++;
            @(negedge clk);
        end
        if (n == WAIT_MAX) check("data_ack_timeout", 64'(in_if.ack), 64'd1);
        @(posedge clk);
        #2;
        in_if.rdy = 1'b0;
    endtask

    task automatic send_record(input logic [REC_W-1:0] rec);
        exp_q.push_back(rec);
        for (int k = 0; k < 6; k++) send_byte(rec[8*k +: 8]);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [REC_W-1:0] rec;
        logic [REC_W-1:0] junk;
        int n;
        int n0;
        int pulses;

        in_if.rdy  = 1'b0;
        in_if.data = 8'h00;
        out_if.ack = 1'b0;
        reset_n    = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_record_rdy", 64'(out_if.rdy), 64'd0);
        check("rst_record", 64'(out_if.data), 64'd0);
        check("rst_lost_count", 64'(lost_count), 64'd0);
        check("rst_resync_err", 64'(resync_err), 64'd0);
        check("rst_data_ack", 64'(in_if.ack), 64'd1);
        idle_cycles(2);
        reset_n = 1'b1;
        idle_cycles(2);

        // Test 1: single record, one-cycle latency
        out_if.ack = 1'b1;
        rec = 48'hFEED_DEAD_BEEF;
        exp_q.push_back(rec);
        for (int k = 0; k < 5; k++) send_byte(rec[8*k +: 8]);
        check("t1_rdy_before_last", 64'(out_if.rdy), 64'd0);
        send_byte(rec[47:40]);
        check("t1_rdy_latency", 64'(out_if.rdy), 64'd1);
        check("t1_record", 64'(out_if.data), 64'(rec));
        check("t1_lost_before_accept", 64'(lost_count), 64'd0);
        idle_cycles(3);
        check("t1_lost_after", 64'(lost_count), 64'(main_lost));

        // Test 2: back-to-back records, no ack drops
        watch_ack = 1'b1;
        ack_drops = 0;
        n0 = deliv_cyc.size();
        send_record(48'h0605_0403_0201);
        send_record(48'h0C0B_0A09_0807);
        idle_cycles(3);
        watch_ack = 1'b0;
        check("t2_ack_drops", 64'(ack_drops), 64'd0);
        check("t2_records", 64'(deliv_cyc.size() - n0), 64'd2);
        if (deliv_cyc.size() - n0 == 2)
            check("t2_spacing", 64'(deliv_cyc[n0+1] - deliv_cyc[n0]), 64'd6);

        // Test 3: output stall, assembly of next record continues, 12th byte blocks
        out_if.ack = 1'b0;
        send_record(48'h1234_5678_9ABC);
        rec = 48'h0FED_CBA9_8765;
        exp_q.push_back(rec);
        for (int k = 0; k < 5; k++) send_byte(rec[8*k +: 8]);
        in_if.rdy  = 1'b1;
        in_if.data = rec[47:40];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_data_ack_stalled", 64'(in_if.ack), 64'd0);
            check("t3_first_held", 64'(out_if.data), 64'h1234_5678_9ABC);
        end
        @(posedge clk);
        #2;
        out_if.ack = 1'b1;
        @(negedge clk);
        check("t3_data_ack_release", 64'(in_if.ack), 64'd1);
        @(posedge clk);
        #2;
        in_if.rdy = 1'b0;
        @(negedge clk);
        check("t3_no_bubble_rdy", 64'(out_if.rdy), 64'd1);
        check("t3_second_record", 64'(out_if.data), 64'(rec));
        idle_cycles(3);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Test 4: lost records, counting and saturation of the 2-bit twin
        for (int r = 0; r < 6; r++) begin
            send_record({8'h80, 32'h0000_0000, 8'(r + 1)});
            idle_cycles(2);
            check("t4_lost_count", 64'(lost_count), 64'(main_lost));
            check("t4_lost_saturating", 64'(lost_sat), 64'(sat_lost));
        end
        check("t4_lost_total", 64'(lost_count), 64'd7);
        check("t4_sat_hold", 64'(lost_sat), 64'd3);

        // Test 5: stalled partial record
        junk = 48'h0000_0033_4455;
        rec  = 48'h0011_2233_4455;
        for (int k = 0; k < 3; k++) send_byte(junk[8*k +: 8]);
`ifdef SAMPLE_DEMUX_TIMEOUT_EN
        n = 0;
        while (n < TIMEOUT + 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (resync_err) break;
        end
        check("t5_timeout_cycles", 64'(n), 64'(TIMEOUT));
        @(negedge clk);
        check("t5_resync_pulse_width", 64'(resync_err), 64'd0);
        check("t5_output_untouched", 64'(out_if.rdy), 64'd0);
        #2;
        send_record(rec);
`else
        pulses = 0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            @(negedge clk);
            if (resync_err) pulses++;
        end
        check("t5_no_resync", 64'(pulses), 64'd0);
        check("t5_no_early_record", 64'(out_if.rdy), 64'd0);
        @(posedge clk);
        #2;
        exp_q.push_back({rec[47:24], junk[23:0]});
        for (int k = 3; k < 6; k++) send_byte(rec[8*k +: 8]);
`endif
        idle_cycles(3);
        check("t5_drained", 64'(exp_q.size()), 64'd0);

        // Test 6: reset mid-record
        junk = 48'hAAAA_5A5A_A5A5;
        for (int k = 0; k < 4; k++) send_byte(junk[8*k +: 8]);
        reset_n   = 1'b0;
        main_lost = 0;
        sat_lost  = 0;
        @(negedge clk);
        check("t6_rst_record_rdy", 64'(out_if.rdy), 64'd0);
        check("t6_rst_record", 64'(out_if.data), 64'd0);
        check("t6_rst_lost_count", 64'(lost_count), 64'd0);
        check("t6_rst_resync_err", 64'(resync_err), 64'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle_cycles(1);
        send_record(48'h7654_3210_FEDC);
        idle_cycles(3);
        check("t6_lost_after_reset", 64'(lost_count), 64'd0);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
